// File: rtl/bcd_seg_scan_pkg.sv
// Shared types and constants for the BCD sampler / 7-segment scanner.
package bcd_seg_scan_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned SEG_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [SEG_W-1:0]   seg_t;

  // Converter result as captured into the shadow registers, d3 is leftmost.
  typedef struct packed {
    digit_t d3;
    digit_t d2;
    digit_t d1;
    digit_t d0;
  } bcd_word_t;

  // Active-low {dp,g,f,e,d,c,b,a}; dp stays dark in every code.
  localparam seg_t SEG_BLANK = 8'hFF;
  localparam seg_t SEG_DASH  = 8'hBF;
  localparam seg_t SEG_0     = 8'hC0;
  localparam seg_t SEG_1     = 8'hF9;
  localparam seg_t SEG_2     = 8'hA4;
  localparam seg_t SEG_3     = 8'hB0;
  localparam seg_t SEG_4     = 8'h99;
  localparam seg_t SEG_5     = 8'h92;
  localparam seg_t SEG_6     = 8'h82;
  localparam seg_t SEG_7     = 8'hF8;
  localparam seg_t SEG_8     = 8'h80;
  localparam seg_t SEG_9     = 8'h90;

endpackage

// File: rtl/bcd_seg_scan_seg7_decode.sv
// Combinational BCD digit to active-low 7-segment code, with blank override.
module seg7_decode
  import bcd_seg_scan_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               blank,
  output logic [SEG_W-1:0]   seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    if (blank) begin
      seg_c = SEG_BLANK;
    end else begin
      case (digit)
        4'd0:    seg_c = SEG_0;
        4'd1:    seg_c = SEG_1;
        4'd2:    seg_c = SEG_2;
        4'd3:    seg_c = SEG_3;
        4'd4:    seg_c = SEG_4;
        4'd5:    seg_c = SEG_5;
        4'd6:    seg_c = SEG_6;
        4'd7:    seg_c = SEG_7;
        4'd8:    seg_c = SEG_8;
        4'd9:    seg_c = SEG_9;
        default: seg_c = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Requests a BCD conversion once per scan frame, captures the settled digits
// and multiplexes them onto a common-anode 4-digit 7-segment display.
module bcd_seg_scan
  import bcd_seg_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned CONV_WAIT = 16,
  parameter bit          BLANK_LZ  = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [DIGIT_W-1:0] bcd3,
  input  logic [DIGIT_W-1:0] bcd2,
  input  logic [DIGIT_W-1:0] bcd1,
  input  logic [DIGIT_W-1:0] bcd0,
  output logic               start,
  output logic [3:0]         an,
  output logic [SEG_W-1:0]   seg
);

  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
  localparam int unsigned WAIT_W = $clog2(CONV_WAIT);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CONV_WAIT - 1);
  localparam logic [1:0]        IDX_LAST  = 2'd3;

  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [1:0]        idx_q, idx_d;
  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  bcd_word_t         shadow_q, shadow_d;
  logic              start_q, start_d;
  logic [3:0]        an_q, an_d;
  seg_t              seg_q, seg_d;

  logic              scan_wrap_c;
  logic              frame_tick_c;
  digit_t            cur_digit_c;
  logic              cur_lz_c;
  logic              cur_blank_c;
  seg_t              dec_seg_c;

  // Free-running digit scan; the frame tick is the index wrapping 3 -> 0.
  always_comb begin
    scan_wrap_c  = (scan_q == SCAN_LAST);
    scan_d       = scan_wrap_c ? '0 : scan_q + SCAN_W'(1);
    idx_d        = scan_wrap_c ? idx_q + 2'd1 : idx_q;
    frame_tick_c = scan_wrap_c && (idx_q == IDX_LAST);
  end

  // Sample FSM: one request in flight, frame ticks while busy are dropped.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    shadow_d = shadow_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_tick_c && enable) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        wait_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wait_d = wait_q + WAIT_W'(1);
        if (wait_d == WAIT_LAST) begin
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        shadow_d = '{d3: bcd3, d2: bcd2, d1: bcd1, d0: bcd0};
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    start_d = (state_d == ST_REQ);
  end

  // Select the scanned digit and whether it is a leading zero.
  always_comb begin
    cur_digit_c = shadow_q.d0;
    cur_lz_c    = 1'b0;
    case (idx_q)
      2'd3: begin
        cur_digit_c = shadow_q.d3;
        cur_lz_c    = (shadow_q.d3 == '0);
      end
      2'd2: begin
        cur_digit_c = shadow_q.d2;
        cur_lz_c    = (shadow_q.d3 == '0) && (shadow_q.d2 == '0);
      end
      2'd1: begin
        cur_digit_c = shadow_q.d1;
        cur_lz_c    = (shadow_q.d3 == '0) && (shadow_q.d2 == '0) && (shadow_q.d1 == '0);
      end
      default: begin
        cur_digit_c = shadow_q.d0;
        cur_lz_c    = 1'b0;
      end
    endcase
    cur_blank_c = BLANK_LZ && cur_lz_c;
  end

  seg7_decode u_dec (
    .digit (cur_digit_c),
    .blank (cur_blank_c),
    .seg_c (dec_seg_c)
  );

  // an and seg come from the same index snapshot so they never disagree.
  always_comb begin
    an_d  = 4'hF;
    seg_d = SEG_BLANK;
    if (enable) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = dec_seg_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_q   <= '0;
      idx_q    <= '0;
      state_q  <= ST_IDLE;
      wait_q   <= '0;
      shadow_q <= '0;
      start_q  <= 1'b0;
      an_q     <= 4'hF;
      seg_q    <= SEG_BLANK;
    end else begin
      scan_q   <= scan_d;
      idx_q    <= idx_d;
      state_q  <= state_d;
      wait_q   <= wait_d;
      shadow_q <= shadow_d;
      start_q  <= start_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign start = start_q;
  assign an    = an_q;
  assign seg   = seg_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Randomized bench for bcd_seg_scan against a cycle-count based reference model.
module tb_bcd_seg_scan;

  localparam int SD    = 4;
  localparam int CW    = 16;
  localparam int FRAME = 4 * SD;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] bcd3 = 4'd0, bcd2 = 4'd0, bcd1 = 4'd0, bcd0 = 4'd0;
  logic       start, start_nb;
  logic [3:0] an, an_nb;
  logic [7:0] seg, seg_nb;

  int errors = 0;
  int checks = 0;
  int n;

  bcd_seg_scan #(.SCAN_DIV(SD), .CONV_WAIT(CW), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
    .start(start), .an(an), .seg(seg)
  );

  bcd_seg_scan #(.SCAN_DIV(SD), .CONV_WAIT(CW), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .enable(enable),
    .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
    .start(start_nb), .an(an_nb), .seg(seg_nb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  function automatic logic [7:0] exp_code(input logic [3:0] v, input bit blank);
    if (blank) return 8'hFF;
    case (v)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hBF;
    endcase
  endfunction

  // Converter stand-in: scrambled digits while busy, target value once done.
  logic [3:0] tgt [4];
  int conv_cnt = 0;

  always @(negedge clk) begin
    if (start === 1'b1) begin
      conv_cnt = 14;
      {bcd3, bcd2, bcd1, bcd0} = 16'($urandom);
    end else if (conv_cnt > 1) begin
      conv_cnt--;
      {bcd3, bcd2, bcd1, bcd0} = 16'($urandom);
    end else if (conv_cnt == 1) begin
      conv_cnt = 0;
      bcd3 = tgt[3];
      bcd2 = tgt[2];
      bcd1 = tgt[1];
      bcd0 = tgt[0];
    end
  end

  // Reference: k counts edges since reset; digit index and frame ticks follow from k.
  int         k = 0;
  bit         busy = 1'b0;
  int         txn_e = 0;
  int         m_idx = 0;
  logic [3:0] m_sh [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic       m_start = 1'b0;
  logic [3:0] m_an = 4'hF, m_an_nb = 4'hF;
  logic [7:0] m_seg = 8'hFF, m_seg_nb = 8'hFF;

  function automatic bit lead_zero(input int i);
    if (i == 0) return 1'b0;
    for (int j = 3; j >= i; j--) begin
      if (m_sh[j] != 4'd0) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      k        = 0;
      busy     = 1'b0;
      m_sh     = '{4'd0, 4'd0, 4'd0, 4'd0};
      m_start  = 1'b0;
      m_an     = 4'hF;
      m_an_nb  = 4'hF;
      m_seg    = 8'hFF;
      m_seg_nb = 8'hFF;
    end else begin
      k++;
      m_idx = ((k - 1) / SD) % 4;
      if (enable) begin
        m_an     = ~(4'b0001 << m_idx);
        m_an_nb  = m_an;
        m_seg    = exp_code(m_sh[m_idx], lead_zero(m_idx));
        m_seg_nb = exp_code(m_sh[m_idx], 1'b0);
      end else begin
        m_an     = 4'hF;
        m_an_nb  = 4'hF;
        m_seg    = 8'hFF;
        m_seg_nb = 8'hFF;
      end
      m_start = 1'b0;
      if (busy) begin
        if (k - 1 == txn_e + CW) begin
          m_sh[3] = bcd3;
          m_sh[2] = bcd2;
          m_sh[1] = bcd1;
          m_sh[0] = bcd0;
          busy    = 1'b0;
        end
      end else if ((k % FRAME == 0) && enable) begin
        busy    = 1'b1;
        txn_e   = k;
        m_start = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if ($time > 5) begin
      check("start", start, m_start);
      check("start_nb", start_nb, m_start);
      check("an", an, m_an);
      check("seg", seg, m_seg);
      check("an_nb", an_nb, m_an_nb);
      check("seg_nb", seg_nb, m_seg_nb);
    end
  end

  task automatic set_tgt(input logic [3:0] d3, input logic [3:0] d2,
                         input logic [3:0] d1, input logic [3:0] d0);
    tgt[3] = d3;
    tgt[2] = d2;
    tgt[1] = d1;
    tgt[0] = d0;
  endtask

  task automatic wait_digit(input bit nb, input logic [3:0] an_val,
                            input logic [7:0] exp_seg, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(posedge clk);
      #1;
      if ((nb ? an_nb : an) === an_val) found = 1'b1;
    end
    if (!found) timeout(name);
    else check(name, nb ? seg_nb : seg, exp_seg);
  endtask

  task automatic wait_start(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk);
      #1;
      if (start === 1'b1) found = 1'b1;
    end
    if (!found) timeout(name);
  endtask

  task automatic count_starts(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (start === 1'b1) cnt++;
    end
  endtask

  initial begin
    set_tgt(4'd1, 4'd2, 4'd3, 4'd4);
    #1 reset = 1'b1;
    #1;
    check("reset_an", an, 4'hF);
    check("reset_seg", seg, 8'hFF);
    check("reset_start", start, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    count_starts(40, n);
    check("first_frame_starts", n, 1);
    wait_digit(1'b0, 4'b0111, 8'hF9, "d3_1234");
    wait_digit(1'b0, 4'b1011, 8'hA4, "d2_1234");
    wait_digit(1'b0, 4'b1101, 8'hB0, "d1_1234");
    wait_digit(1'b0, 4'b1110, 8'h99, "d0_1234");

    set_tgt(4'd0, 4'd0, 4'd0, 4'd7);
    repeat (90) @(negedge clk);
    wait_digit(1'b0, 4'b0111, 8'hFF, "d3_7_blank");
    wait_digit(1'b0, 4'b1011, 8'hFF, "d2_7_blank");
    wait_digit(1'b0, 4'b1101, 8'hFF, "d1_7_blank");
    wait_digit(1'b0, 4'b1110, 8'hF8, "d0_7");
    wait_digit(1'b1, 4'b0111, 8'hC0, "d3_7_noblank");
    wait_digit(1'b1, 4'b1101, 8'hC0, "d1_7_noblank");

    set_tgt(4'd0, 4'd0, 4'd0, 4'd0);
    repeat (90) @(negedge clk);
    wait_digit(1'b0, 4'b0111, 8'hFF, "d3_0_blank");
    wait_digit(1'b0, 4'b1110, 8'hC0, "d0_0");

    set_tgt(4'd9, 4'd9, 4'd9, 4'd9);
    repeat (90) @(negedge clk);
    wait_digit(1'b0, 4'b0111, 8'h90, "d3_9999");
    wait_digit(1'b0, 4'b1110, 8'h90, "d0_9999");

    set_tgt(4'd1, 4'hB, 4'd2, 4'd3);
    repeat (90) @(negedge clk);
    wait_digit(1'b0, 4'b1011, 8'hBF, "d2_illegal");

    // Drop enable mid-conversion; the capture still lands while dark.
    set_tgt(4'd4, 4'd5, 4'd6, 4'd7);
    wait_start("start_before_disable");
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("disable_an", an, 4'hF);
    check("disable_seg", seg, 8'hFF);
    count_starts(80, n);
    check("disabled_starts", n, 0);
    @(negedge clk);
    enable = 1'b1;
    count_starts(20, n);
    check("reenable_starts", n, 1);
    wait_digit(1'b0, 4'b0111, 8'h99, "d3_after_reenable");

    // Asynchronous reset in the middle of a conversion wait.
    wait_start("start_before_reset");
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midwait_reset_an", an, 4'hF);
    check("midwait_reset_seg", seg, 8'hFF);
    check("midwait_reset_start", start, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_an", an, 4'b1110);
    check("post_reset_seg", seg, 8'hC0);
    count_starts(20, n);
    check("post_reset_starts", n, 1);

    repeat (1500) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 3) begin
        int lead;
        lead = $urandom_range(0, 3);
        for (int i = 0; i < 4; i++) begin
          if (i > 3 - lead) tgt[i] = 4'd0;
          else if ($urandom_range(0, 9) == 0) tgt[i] = 4'($urandom_range(10, 15));
          else tgt[i] = 4'($urandom_range(0, 9));
        end
      end
      if ($urandom_range(0, 199) == 0) enable = ~enable;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
